patch_eq_sweeper: RTL

// - Stimulus/response end of the ECO patch interface: exhaustively sweeps all 2^NUM_IN input vectors

---
 rtl/patch_eq_sweeper.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/patch_eq_sweeper.sv
// Exhaustive stimulus/response sweeper: drives every NUM_IN-bit vector into a patch and a golden cone
// and compares their outputs. Define PATCH_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module patch_eq_sweeper #(
   parameter int NUM_IN = 4,
   parameter int LAT    = 0,
   parameter int CNT_W  = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [NUM_IN-1:0] vec_out,
   output logic              vec_valid,
   input  logic              dut_out,
   input  logic              gold_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [NUM_IN-1:0] fail_vec,
   output logic [CNT_W-1:0]  mismatch_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [NUM_IN-1:0]   vec_q, vec_d;
   logic                vld_q, vld_d;
   logic [2:0]          drain_q, drain_d;
   logic                pass_q, pass_d;
   logic [NUM_IN-1:0]   fail_vec_q, fail_vec_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [NUM_IN-1:0]   cmp_vec;
   logic                cmp_vld;
   logic                mismatch;
   logic                count_en;
   logic                stop_hit;

   localparam logic [NUM_IN-1:0] LAST_VEC = {NUM_IN{1'b1}};
   localparam logic [2:0]        DRAIN_END = 3'(LAT);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (&c) return c;
      return c + CNT_W'(1);
   endfunction

   // Align the issued vector with the patch/golden response arriving LAT cycles later.
   generate
      if (LAT == 0) begin : g_no_delay
         assign cmp_vec = vec_q;
         assign cmp_vld = vld_q;
      end else begin : g_delay
         logic              vld_pipe_q [LAT];
         logic [NUM_IN-1:0] vec_pipe_q [LAT];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < LAT; i++) vld_pipe_q[i] <= 1'b0;
            end else begin
               vld_pipe_q[0] <= vld_q;
               for (int i = 1; i < LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            vec_pipe_q[0] <= vec_q;
            for (int i = 1; i < LAT; i++) vec_pipe_q[i] <= vec_pipe_q[i-1];
         end

         assign cmp_vec = vec_pipe_q[LAT-1];
         assign cmp_vld = vld_pipe_q[LAT-1];
      end
   endgenerate

   // Gating on cmp_vld keeps X on the response pins out of the result.
   assign mismatch = cmp_vld ? (dut_out ^ gold_out) : 1'b0;

`ifdef PATCH_STOP_ON_FAIL_EN
   logic stop_q, stop_d;

   assign count_en = mismatch & ~stop_q;
   assign stop_hit = count_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stop_q <= 1'b0;
      else     stop_q <= stop_d;
   end
`else
   assign count_en = mismatch;
   assign stop_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      vld_d      = vld_q;
      drain_d    = drain_q;
      pass_d     = pass_q;
      fail_vec_d = fail_vec_q;
      cnt_d      = cnt_q;
`ifdef PATCH_STOP_ON_FAIL_EN
      stop_d     = stop_q;
`endif

      if (count_en) begin
         if (cnt_q == '0) fail_vec_d = cmp_vec;
         cnt_d = sat_inc(cnt_q);
`ifdef PATCH_STOP_ON_FAIL_EN
         stop_d = 1'b1;
`endif
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_RUN;
               vec_d      = '0;
               vld_d      = 1'b1;
               cnt_d      = '0;
               fail_vec_d = '0;
               pass_d     = 1'b0;
`ifdef PATCH_STOP_ON_FAIL_EN
               stop_d     = 1'b0;
`endif
            end
         end
         S_RUN: begin
            if (vec_q == LAST_VEC || stop_hit) begin
               state_d = S_DRAIN;
               vld_d   = 1'b0;
               drain_d = '0;
            end else begin
               vec_d = vec_q + NUM_IN'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_END) begin
               state_d = S_DONE;
               pass_d  = (cnt_d == '0);
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         vec_q      <= '0;
         vld_q      <= 1'b0;
         drain_q    <= '0;
         pass_q     <= 1'b0;
         fail_vec_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         vld_q      <= vld_d;
         drain_q    <= drain_d;
         pass_q     <= pass_d;
         fail_vec_q <= fail_vec_d;
         cnt_q      <= cnt_d;
      end
   end

   assign vec_out      = vec_q;
   assign vec_valid    = vld_q;
   assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done         = (state_q == S_DONE);
   assign pass         = pass_q;
   assign fail_vec     = fail_vec_q;
   assign mismatch_cnt = cnt_q;

endmodule
